// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//
// Synchronous up-counter with enable, modulo wrap and a registered
// terminal-count pulse. Intended as a generic timebase / debug event counter.
// The default configuration is a 4-bit modulo-16 counter stepping by one.
//
// Parameters
//   WIDTH        bit width of counter_out
//   MAX_COUNT    last value before wrap (legal 1 .. 2**WIDTH-1)
//   STEP         increment per enabled edge (legal 1 .. MAX_COUNT)
//   RESET_VALUE  value loaded by reset (must be <= MAX_COUNT)
//
// Ports
//   clock        in   1      rising-edge clock, only clock of the block
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      count enable, sampled on the rising edge
//   counter_out  out  WIDTH  current count, registered
//   wrap         out  1      default build: one-cycle pulse in the cycle
//                            counter_out shows the post-wrap value;
//                            saturating build: level "saturated" flag
//
// Build option
//   COUNTER_SATURATE_EN  when defined the counter clamps at MAX_COUNT instead
//                        of wrapping, and wrap is high whenever counter_out
//                        equals MAX_COUNT (until reset). When undefined the
//                        modulo-wrap behaviour with a one-cycle pulse is used.
//
// Priority on every edge: reset > enable > hold. The register contents are
// undefined until the first reset edge.
// -----------------------------------------------------------------------------
module counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_COUNT   = 2**WIDTH - 1,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             wrap
);

  // All compare/add arithmetic is carried one bit wider than the count so
  // that count + STEP can never overflow before it is compared.
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);
`ifndef COUNTER_SATURATE_EN
  // Modulus of the wrap; 2**WIDTH in the default build, hence WIDTH+1 bits.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MAX_COUNT + 1);
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic [WIDTH:0]   sum_w;
  logic             fits_w;

  // Candidate next value and whether it still lies inside 0..MAX_COUNT.
  // Testing sum <= MAX is the same as count <= MAX-STEP without needing a
  // subtraction that could go negative.
  assign sum_w  = {1'b0, count_q} + STEP_W;
  assign fits_w = (sum_w <= MAX_W);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
`ifdef COUNTER_SATURATE_EN
    if (enable) begin
      if (fits_w) begin
        count_d = WIDTH'(sum_w);
      end else begin
        count_d = MAX_V;
      end
    end
    // Level flag: follows "count sits at MAX". Once at MAX the count can only
    // leave through reset, so the flag is effectively cleared only by reset.
    wrap_d = (count_d == MAX_V);
`else
    if (enable) begin
      if (fits_w) begin
        count_d = WIDTH'(sum_w);
      end else begin
        // Overshoot past MAX folds back to the bottom of the range.
        count_d = WIDTH'(sum_w - MOD_W);
        wrap_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_V;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign counter_out = count_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter
//
// Drives three counter instances from a shared clock/reset/enable:
//   a: defaults (4-bit, modulo 16, step 1)
//   b: MAX_COUNT=9, STEP=3
//   c: MAX_COUNT=12, STEP=5, RESET_VALUE=5
// Expected {wrap, count} values come from an arithmetic model of the counting
// rules and are queued per edge, then popped and compared one time unit after
// the rising edge. Directed checks with literal values cover the named
// scenarios; a randomized tail exercises reset/enable mixes.
// -----------------------------------------------------------------------------
module tb_counter;

  localparam int N = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  always #5 clock = ~clock;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       wr_a,  wr_b,  wr_c;

  counter dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .counter_out(cnt_a), .wrap(wr_a)
  );

  counter #(.WIDTH(4), .MAX_COUNT(9), .STEP(3), .RESET_VALUE(0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .counter_out(cnt_b), .wrap(wr_b)
  );

  counter #(.WIDTH(4), .MAX_COUNT(12), .STEP(5), .RESET_VALUE(5)) dut_c (
    .clock(clock), .reset(reset), .enable(enable),
    .counter_out(cnt_c), .wrap(wr_c)
  );

  // ---------------------------------------------------------------- model
  int max_c  [N] = '{15, 9, 12};
  int step_c [N] = '{1, 3, 5};
  int rv_c   [N] = '{0, 0, 5};
  int m_cnt  [N];
  int m_wr   [N];

  logic [4:0] exp_q[$];

  int tests_run = 0;
  int failed    = 0;

  // Advance the model by one rising edge using the inputs present at that
  // edge and queue the expected {wrap, count} of each instance.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_cnt[i] = rv_c[i];
        m_wr[i]  = 0;
      end else if (enable) begin
`ifdef COUNTER_SATURATE_EN
        m_cnt[i] = (m_cnt[i] + step_c[i] > max_c[i]) ? max_c[i] : m_cnt[i] + step_c[i];
        m_wr[i]  = (m_cnt[i] == max_c[i]) ? 1 : 0;
`else
        m_wr[i]  = (m_cnt[i] + step_c[i] > max_c[i]) ? 1 : 0;
        m_cnt[i] = (m_cnt[i] + step_c[i]) % (max_c[i] + 1);
`endif
      end else begin
`ifdef COUNTER_SATURATE_EN
        m_wr[i] = (m_cnt[i] == max_c[i]) ? 1 : 0;
`else
        m_wr[i] = 0;
`endif
      end
      exp_q.push_back({1'(m_wr[i]), 4'(m_cnt[i])});
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [4:0] obs);
    logic [4:0] exp;
    if (exp_q.size() == 0) begin
      tests_run++;
      failed++;
      $error("FAIL %s: observed %0h expected <queue empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      check_val(tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input logic rst, input logic en, input string tag);
    reset  = rst;
    enable = en;
    @(posedge clock);
    model_edge();
    #1;
    sb_check({tag, "/a"}, {wr_a, cnt_a});
    sb_check({tag, "/b"}, {wr_b, cnt_b});
    sb_check({tag, "/c"}, {wr_c, cnt_c});
  endtask

  // ---------------------------------------------------------------- stimulus
`ifdef COUNTER_SATURATE_EN
  int seq_b [7] = '{3, 6, 9, 9, 9, 9, 9};
  int wrs_b [7] = '{0, 0, 1, 1, 1, 1, 1};
`else
  int seq_b [7] = '{3, 6, 9, 2, 5, 8, 1};
  int wrs_b [7] = '{0, 0, 0, 1, 0, 0, 1};
`endif

  initial begin
    int wrap_seen;
    logic r, e;

    // Reset held with enable low, then with enable high.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, "reset_en0");
      check_val("reset_en0_lit", {wr_a, cnt_a}, 5'h00);
    end
    step(1'b1, 1'b1, "reset_en1");
    check_val("reset_en1_lit", {wr_a, cnt_a}, 5'h00);
    check_val("reset_c_value", {wr_c, cnt_c}, 5'h05);

    // Twenty enabled edges from zero.
    wrap_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, "count");
`ifdef COUNTER_SATURATE_EN
      check_val("count_lit", {wr_a, cnt_a},
                (i >= 14) ? 5'h1F : {1'b0, 4'(i + 1)});
`else
      check_val("count_lit", {wr_a, cnt_a},
                (i == 15) ? 5'h10 : {1'b0, 4'((i + 1) % 16)});
`endif
      if (wr_a) wrap_seen++;
    end
`ifdef COUNTER_SATURATE_EN
    check_val("sat_flag_cycles", 5'(wrap_seen), 5'd6);
`else
    check_val("wrap_pulse_count", 5'(wrap_seen), 5'd1);
`endif

    // Hold at 7 for four edges, then advance once.
    step(1'b1, 1'b0, "hold_rst");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "hold_up");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, "hold");
      check_val("hold_lit", {wr_a, cnt_a}, 5'h07);
    end
    step(1'b0, 1'b1, "hold_resume");
    check_val("hold_resume_lit", {wr_a, cnt_a}, 5'h08);

    // Reset at count 15 with enable high suppresses the wrap.
    step(1'b1, 1'b0, "mid_rst0");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "mid_up");
    check_val("mid_at15", {1'b0, cnt_a}, 5'h0F);
    step(1'b1, 1'b1, "mid_rst");
    check_val("mid_rst_lit", {wr_a, cnt_a}, 5'h00);
    step(1'b0, 1'b1, "mid_resume");
    check_val("mid_resume_lit", {wr_a, cnt_a}, 5'h01);

    // MAX_COUNT=9 / STEP=3 sequence on instance b.
    step(1'b1, 1'b0, "param_rst");
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, "param");
      check_val("param_seq_b", {wr_b, cnt_b}, {1'(wrs_b[i]), 4'(seq_b[i])});
    end

    // Randomized reset/enable mix.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, "random");
    end

    check_val("queue_drained", 5'(exp_q.size()), 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Synchronous up-counter with enable, modulo wrap and a registered terminal-count pulse.
- Generic free-running event/cycle counter used as a timebase or debug counter; default configuration is a 4-bit modulo-16 counter.
- All outputs are registered and driven from a single clock domain.

Parameters:
- WIDTH, 4, bit width of counter_out.
- MAX_COUNT, 2**WIDTH-1, last value before wrap; legal range 1..2**WIDTH-1.
- STEP, 1, increment per enabled cycle; legal range 1..MAX_COUNT.
- RESET_VALUE, 0, value loaded by reset; must be <= MAX_COUNT.

Ports:
- clock  input  1  rising-edge clock, only clock of the block.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable, sampled on rising clock edge.
- counter_out  output  WIDTH  current count, registered.
- wrap  output  1  one-cycle pulse coincident with the cycle counter_out shows the post-wrap value.
- Port order is fixed: clock, reset, enable, counter_out, wrap. Positional instantiation with only the first four ports connected is supported; wrap may be left unconnected.

Behaviour:
- All state updates on the rising edge of clock only; no asynchronous paths.
- Priority per edge: reset > enable > hold.
- Reset (reset=1 at edge): counter_out <= RESET_VALUE, wrap <= 0, regardless of enable.
- Counter state is undefined between power-up and the first reset edge; no initial-value requirement.
- Enable=1, reset=0: if counter_out <= MAX_COUNT-STEP then counter_out <= counter_out+STEP, wrap <= 0; else counter_out <= counter_out+STEP-(MAX_COUNT+1), wrap <= 1.
- Arithmetic is done at WIDTH+1 bits internally so the compare/add never overflows; counter_out never exceeds MAX_COUNT.
- Enable=0, reset=0: counter_out holds, wrap <= 0.
- Latency: one clock from enable sampled high to counter_out change.
- Default config: 0,1,...,15,0,... with wrap=1 during the cycle counter_out=0 after 15.
- Reset mid-count: the next edge loads RESET_VALUE and clears a pending wrap pulse; counting resumes on the first enabled edge after reset deasserts.
- Enable toggling: each enabled edge advances exactly one STEP; no sticky state.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: no wrap. When counter_out > MAX_COUNT-STEP on an enabled edge, counter_out <= MAX_COUNT and holds there while enable stays high. wrap becomes a level "saturated" flag: 1 whenever counter_out == MAX_COUNT, cleared only by reset.
- Undefined: modulo wrap behaviour and one-cycle wrap pulse as specified above.

Test Plan:
- Reset: hold reset=1 for 5 edges with enable=0, then enable=1 with reset=1 -> counter_out=0, wrap=0 on every edge.
- Count and wrap (defaults): deassert reset, enable=1 for 20 edges -> counter_out 1..15,0,1,2,3,4. wrap=1 exactly on the edge counter_out goes 15->0.
- Hold: count to 7, enable=0 for 4 edges, then re-enable -> counter_out stays 7 for 4 edges, then reads 8 on the next enabled edge.
- Reset mid-count: at counter_out=15 with enable=1, assert reset for one edge -> counter_out=0, wrap=0 (no wrap pulse). The next enabled edge gives counter_out=1.
- Parameterised: WIDTH=4, MAX_COUNT=9, STEP=3, from 0 -> sequence 3,6,9,2,5,8,1. wrap=1 on the 9->2 and 8->1 transitions.
- COUNTER_SATURATE_EN defined, defaults: enable for 20 edges -> counter_out reaches 15 and holds. wrap=1 from the first cycle at 15 until reset.
